// File: rtl/fp_mul_pkg.sv
// Shared constants and helpers for the FP multiplier exponent path,
// including the shared 12-bit adder arbiter.
package fp_mul_pkg;
  localparam int ADDER_W     = 12;
  localparam int NUM_REQ_DEF = 4;
  localparam int MAX_REQ     = 8;
  localparam int BUS_W       = MAX_REQ * ADDER_W;

  typedef enum logic { EMPTY = 1'b0, FULL = 1'b1 } res_state_t;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Operand buses are zero-extended to the widest supported requester count.
  function automatic logic [ADDER_W-1:0] opnd_slice(input logic [BUS_W-1:0] bus,
                                                    input int idx);
    return bus[idx*ADDER_W +: ADDER_W];
  endfunction
endpackage

// File: rtl/adder12.sv
// Existing 12-bit unsigned adder; carry out is discarded.
module adder12 (
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [11:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/adder12_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);
  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/adder12_arbiter.sv
// Round-robin sharing of one adder12 among NUM_REQ requesters with a
// registered, ID-tagged result; one add per cycle under back-to-back load.
module adder12_arbiter
  import fp_mul_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDER_W-1:0] req_a,
  input  logic [NUM_REQ*ADDER_W-1:0] req_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ADDER_W-1:0]         res_sum,
  output logic [ID_W-1:0]            res_id,
  output logic                       busy
);
  res_state_t         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               can_load, xfer;
  logic [ADDER_W-1:0] op_a, op_b, sum_nxt;
  logic [BUS_W-1:0]   a_bus, b_bus;

  assign res_valid = (state_q == FULL);
  assign can_load  = !res_valid | res_ready;
  assign busy      = res_valid | (|req_valid);

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // rst_n gates the grant so no requester is accepted while held in reset.
  assign req_ready = gnt & {NUM_REQ{can_load & rst_n}};
  assign xfer      = |req_ready;

  assign a_bus = BUS_W'(req_a);
  assign b_bus = BUS_W'(req_b);
  assign op_a  = opnd_slice(a_bus, int'(gnt_idx));
  assign op_b  = opnd_slice(b_bus, int'(gnt_idx));

  adder12 u_add (.a(op_a), .b(op_b), .sum(sum_nxt));

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (xfer) state_d = FULL;
      FULL:    if (!xfer && res_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      res_sum <= '0;
      res_id  <= '0;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        res_sum <= sum_nxt;
        res_id  <= gnt_idx;
        rr_ptr  <= (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_adder12_arbiter.sv
// Directed bench for adder12_arbiter: vector table plus back-pressure and
// mid-operation reset sequences.
module tb_adder12_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [47:0] req_a, req_b;
  logic        res_valid, res_ready, busy;
  logic [11:0] res_sum;
  logic [1:0]  res_id;

  int errors = 0;
  int checks = 0;

  adder12_arbiter #(.NUM_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       valid;
    logic [3:0][11:0] a;
    logic [3:0][11:0] b;
    logic [3:0]       exp_ready;
    logic             exp_valid;
    logic [11:0]      exp_sum;
    logic [1:0]       exp_id;
  } vec_t;

  vec_t tab[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    logic [3:0][11:0] la, lb, la2, lb2;
    // lane sums: 0x111, 0x579, 0x000 (wrap), 0x001 (wrap)
    la  = {12'hFFF, 12'h7FF, 12'h123, 12'h100};
    lb  = {12'h002, 12'h801, 12'h456, 12'h011};
    la2 = {12'hFFF, 12'h7FF, 12'h123, 12'hABC};
    lb2 = {12'h002, 12'h801, 12'h456, 12'h555};

    tab[0]  = '{4'b1111, la,  lb,  4'b0001, 1'b1, 12'h111, 2'd0};
    tab[1]  = '{4'b1111, la,  lb,  4'b0010, 1'b1, 12'h579, 2'd1};
    tab[2]  = '{4'b1111, la,  lb,  4'b0100, 1'b1, 12'h000, 2'd2};
    tab[3]  = '{4'b1111, la,  lb,  4'b1000, 1'b1, 12'h001, 2'd3};
    tab[4]  = '{4'b1111, la,  lb,  4'b0001, 1'b1, 12'h111, 2'd0};
    tab[5]  = '{4'b1111, la,  lb,  4'b0010, 1'b1, 12'h579, 2'd1};
    tab[6]  = '{4'b1001, la,  lb,  4'b1000, 1'b1, 12'h001, 2'd3};
    tab[7]  = '{4'b0010, la,  lb,  4'b0010, 1'b1, 12'h579, 2'd1};
    tab[8]  = '{4'b0001, la2, lb2, 4'b0001, 1'b1, 12'h011, 2'd0};
    tab[9]  = '{4'b0000, la,  lb,  4'b0000, 1'b0, 12'h011, 2'd0};
    tab[10] = '{4'b0110, la,  lb,  4'b0010, 1'b1, 12'h579, 2'd1};
    tab[11] = '{4'b0000, la,  lb,  4'b0000, 1'b0, 12'h579, 2'd1};

    // reset held with every requester asking
    rst_n = 1'b0; req_valid = 4'b1111; req_a = la; req_b = lb; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst res_valid", res_valid, 0);
    chk("rst req_ready", req_ready, 0);
    chk("rst res_sum", res_sum, 0);
    chk("rst res_id", res_id, 0);
    chk("rst busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      req_valid = tab[i].valid; req_a = tab[i].a; req_b = tab[i].b;
      #1;
      chk($sformatf("v%0d req_ready", i), req_ready, tab[i].exp_ready);
      @(posedge clk); #1;
      chk($sformatf("v%0d res_valid", i), res_valid, tab[i].exp_valid);
      chk($sformatf("v%0d res_sum", i), res_sum, tab[i].exp_sum);
      chk($sformatf("v%0d res_id", i), res_id, tab[i].exp_id);
    end
    chk("idle busy", busy, 0);

    // back-pressure: rr_ptr=2, result register empty
    req_valid = 4'b1111; req_a = la; req_b = lb; res_ready = 1'b0;
    #1;
    chk("bp load ready", req_ready, 4'b0100);
    @(posedge clk); #1;
    chk("bp load id", res_id, 2);
    chk("bp load sum", res_sum, 12'h000);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d req_ready", c), req_ready, 0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d res_valid", c), res_valid, 1);
      chk($sformatf("bp%0d res_sum", c), res_sum, 12'h000);
      chk($sformatf("bp%0d res_id", c), res_id, 2);
    end
    res_ready = 1'b1;
    #1;
    chk("bp release ready", req_ready, 4'b1000);
    @(posedge clk); #1;
    chk("bp release valid", res_valid, 1);
    chk("bp release id", res_id, 3);
    chk("bp release sum", res_sum, 12'h001);
    chk("rr wrap ready", req_ready, 4'b0001);
    @(posedge clk); #1;
    chk("rr wrap id", res_id, 0);

    // mid-operation reset with rr_ptr=1 and a result pending
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst res_valid", res_valid, 0);
    chk("mid rst req_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post rst ready", req_ready, 4'b0001);
    @(posedge clk); #1;
    chk("post rst valid", res_valid, 1);
    chk("post rst id", res_id, 0);
    chk("post rst sum", res_sum, 12'h111);

    req_valid = 4'b0000;
    @(posedge clk); #1;
    chk("final drain valid", res_valid, 0);
    chk("final busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
